// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential N-bit ALU: opcode map, FSM state
// encoding and a shift-opcode helper.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative shifter: one bit position per cycle. start_i loads the operand,
// opcode and a non-zero count; done_o flags the cycle that performs the last
// step, and result_o is the value after the current cycle's step.
module alu_shift_iter
    import alu_seq_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   amt_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q;
    logic [3:0]       op_q;
    logic             busy_q;

    // One-position shift of the working register; fill bit depends on opcode.
    always_comb begin
        work_d = work_q;
        case (op_q)
            OP_SRL:  work_d = {1'b0, work_q[WIDTH-1:1]};
            OP_SLL:  work_d = {work_q[WIDTH-2:0], 1'b0};
            default: work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        endcase
    end

    assign result_o = work_d;
    assign done_o   = busy_q && (cnt_q == SHW'(1));

    // Load on start, then step and count down until the terminal count of 1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            work_q <= '0;
            cnt_q  <= '0;
            op_q   <= OP_AND;
            busy_q <= 1'b0;
        end else if (start_i) begin
            work_q <= data_i;
            cnt_q  <= amt_i;
            op_q   <= op_i;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            work_q <= work_d;
            cnt_q  <= cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq_n.sv
// Sequential N-bit ALU with valid/ready on both sides. Logic/arithmetic ops
// finish in one cycle; shifts iterate one bit per cycle in alu_shift_iter.
// Optional macro ALU_SEQ_FLAGS_EN adds registered zero_o / ovf_o outputs.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a request; non-shift and shift-by-0 complete here
// ST_SHIFT | shifter stepping, one position per cycle
// ST_DONE  | result valid and held until the consumer accepts it
module alu_seq_n
    import alu_seq_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic [3:0]       operacion_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] resultado_o,
`ifdef ALU_SEQ_FLAGS_EN
    output logic             zero_o,
    output logic             ovf_o,
`endif
    output logic             c_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             c_q, c_d;

    logic             use_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic             add_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;

    logic             shift_start;
    logic             shift_done;
    logic [WIDTH-1:0] shift_res;

`ifdef ALU_SEQ_FLAGS_EN
    logic zero_q, zero_d;
    logic ovf_q, ovf_d;
`endif

    alu_shift_iter #(.WIDTH(WIDTH)) u_shift (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (shift_start),
        .op_i     (operacion_i),
        .data_i   (a_i),
        .amt_i    (b_i[SHW-1:0]),
        .done_o   (shift_done),
        .result_o (shift_res)
    );

    // Single-cycle unit: shared adder (SLT/SLTU always subtract) and result mux.
    always_comb begin
        use_sub = (operacion_i != OP_ADD) || sub_i;
        b_eff   = use_sub ? ~b_i : b_i;
        sum_ext = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, use_sub};
        add_ovf = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_ext[WIDTH-1] != a_i[WIDTH-1]);
        alu_res = '0;
        alu_c   = 1'b0;
        case (operacion_i)
            OP_AND:  alu_res = a_i & b_i;
            OP_OR:   alu_res = a_i | b_i;
            OP_XOR:  alu_res = a_i ^ b_i;
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
            end
            OP_SLT: begin
                alu_res = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH-1] ^ add_ovf};
                alu_c   = sum_ext[WIDTH];
            end
            OP_SLTU: begin
                alu_res = {{(WIDTH-1){1'b0}}, ~sum_ext[WIDTH]};
                alu_c   = sum_ext[WIDTH];
            end
            // Only reached for a zero shift amount: operand passes through.
            OP_SRL, OP_SLL, OP_SRA: alu_res = a_i;
            default: alu_res = '0;
        endcase
    end

    // Next-state, handshake outputs and result register loads.
    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        c_d         = c_q;
        shift_start = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
        zero_d      = zero_q;
        ovf_d       = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    if (is_shift(operacion_i) && (b_i[SHW-1:0] != '0)) begin
                        shift_start = 1'b1;
                        c_d         = 1'b0;
                        state_d     = ST_SHIFT;
                    end else begin
                        res_d   = alu_res;
                        c_d     = alu_c;
`ifdef ALU_SEQ_FLAGS_EN
                        zero_d  = (alu_res == '0);
                        ovf_d   = (operacion_i == OP_ADD) && add_ovf;
`endif
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    res_d   = shift_res;
                    c_d     = 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
                    zero_d  = (shift_res == '0);
                    ovf_d   = 1'b0;
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers; reset discards any in-flight operation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            c_q     <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            c_q     <= c_d;
`ifdef ALU_SEQ_FLAGS_EN
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign resultado_o = res_q;
    assign c_o         = c_q;
`ifdef ALU_SEQ_FLAGS_EN
    assign zero_o      = zero_q;
    assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq_n.sv
// Bench for alu_seq_n at WIDTH=8: directed steps then random requests,
// checked against an integer-arithmetic reference model.
module tb_alu_seq_n;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         sub;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         c;
`ifdef ALU_SEQ_FLAGS_EN
    logic         zero, ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_seq_n #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .sub_i       (sub),
        .operacion_i (op),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .resultado_o (res),
`ifdef ALU_SEQ_FLAGS_EN
        .zero_o      (zero),
        .ovf_o       (ovf),
`endif
        .c_o         (c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {carry, result} from plain integer arithmetic.
    function automatic logic [8:0] ref_alu(input logic [3:0] o, input logic [7:0] aa,
                                           input logic [7:0] bb, input logic s);
        int ua, ub, sa, sb, sh, r, cy;
        ua = int'(aa);
        ub = int'(bb);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        sh = ub % 8;
        r  = 0;
        cy = 0;
        case (o)
            4'd0: r = ua & ub;
            4'd1: r = ua | ub;
            4'd2: begin
                if (s) begin
                    r  = (ua - ub + 256) % 256;
                    cy = (ua >= ub) ? 1 : 0;
                end else begin
                    r  = (ua + ub) % 256;
                    cy = (ua + ub > 255) ? 1 : 0;
                end
            end
            4'd3: begin
                r  = (sa < sb) ? 1 : 0;
                cy = (ua >= ub) ? 1 : 0;
            end
            4'd4: r = ua ^ ub;
            4'd5: begin
                r  = (ua < ub) ? 1 : 0;
                cy = (ua >= ub) ? 1 : 0;
            end
            4'd6: r = ua >> sh;
            4'd7: r = (ua << sh) % 256;
            4'd8: r = (sa >>> sh) & 255;
            default: r = 0;
        endcase
        return {cy[0], r[7:0]};
    endfunction

    function automatic logic ref_ovf(input logic [3:0] o, input logic [7:0] aa,
                                     input logic [7:0] bb, input logic s);
        int sa, sb, t;
        sa = (int'(aa) > 127) ? int'(aa) - 256 : int'(aa);
        sb = (int'(bb) > 127) ? int'(bb) - 256 : int'(bb);
        t  = s ? sa - sb : sa + sb;
        return (o == 4'd2) && ((t > 127) || (t < -128));
    endfunction

    // One full request: accept, latency/busy checks, optional stall, handshake.
    task automatic run_req(input logic [3:0] o, input logic [7:0] aa, input logic [7:0] bb,
                           input logic s, input int stall, input string tag);
        logic [8:0] exp;
        int         lat, exp_lat, sh;
        exp     = ref_alu(o, aa, bb, s);
        sh      = int'(bb[2:0]);
        exp_lat = ((o == 4'd6 || o == 4'd7 || o == 4'd8) && sh != 0) ? 1 + sh : 1;
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        op       = o;
        a        = aa;
        b        = bb;
        sub      = s;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        while (!out_valid && lat < 3 * W) begin
            chk({tag, "_busy_rdy"}, 32'(in_ready), 32'd0);
            in_valid = 1'($urandom);
            a        = 8'($urandom);
            b        = 8'($urandom);
            op       = 4'($urandom);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, 32'(res), 32'(exp[7:0]));
        chk({tag, "_c"}, 32'(c), 32'(exp[8]));
`ifdef ALU_SEQ_FLAGS_EN
        chk({tag, "_zero"}, 32'(zero), 32'(exp[7:0] == 8'h00));
        chk({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(o, aa, bb, s)));
`endif
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            a         = 8'($urandom);
            op        = 4'($urandom);
            @(negedge clk);
            chk({tag, "_hold_v"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_res"}, 32'(res), 32'(exp[7:0]));
            chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_post_v"}, 32'(out_valid), 32'd0);
        chk({tag, "_post_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        a         = 8'hF0;
        b         = 8'h20;
        sub       = 1'b0;
        op        = 4'd2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_res", 32'(res), 32'd0);
        chk("rst_c", 32'(c), 32'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        chk("rst_drop", 32'(out_valid), 32'd0);

        run_req(4'd2, 8'hF0, 8'h20, 1'b0, 0, "add");
        run_req(4'd2, 8'h05, 8'h07, 1'b1, 0, "sub");
        run_req(4'd3, 8'h05, 8'h07, 1'b0, 0, "slt");
        run_req(4'd5, 8'hFF, 8'h01, 1'b0, 0, "sltu");
        run_req(4'd3, 8'hFF, 8'h01, 1'b1, 0, "slt_neg");
        run_req(4'd2, 8'h70, 8'h20, 1'b0, 0, "add_ovf");
        run_req(4'd8, 8'h90, 8'h03, 1'b0, 0, "sra");
        run_req(4'd6, 8'h90, 8'h03, 1'b0, 0, "srl");
        run_req(4'd7, 8'h03, 8'h07, 1'b0, 0, "sll7");
        run_req(4'd7, 8'h5C, 8'h08, 1'b0, 0, "sll0");
        run_req(4'd4, 8'hA5, 8'hFF, 1'b0, 5, "xor_bp");

        @(negedge clk);
        op       = 4'd8;
        a        = 8'h90;
        b        = 8'h03;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_res", 32'(res), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_c", 32'(c), 32'd0);

        run_req(4'd0, 8'hCC, 8'hAA, 1'b0, 0, "and");
        run_req(4'd15, 8'h37, 8'h11, 1'b1, 0, "undef");
        run_req(4'd1, 8'h00, 8'h00, 1'b0, 1, "or_zero");

        for (int i = 0; i < 40; i++) begin
            logic [3:0] ro;
            ro = (i % 3 == 0) ? 4'($urandom_range(6, 8)) : 4'($urandom_range(0, 15));
            run_req(ro, 8'($urandom), 8'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
